// File: rtl/direction_scheduler.sv
// Button-driven direction scheduler: synchronises and debounces four buttons,
// arbitrates presses, filters reversals and holds up to two pending turns for the game tick.
module direction_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BTNU,
  input  logic       BTNR,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       tick,
  output logic [2:0] dir,
  output logic       dir_changed,
  output logic [1:0] queue_count,
  output logic       reject,
  output logic       drop
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] DirUp    = 3'd1;
  localparam logic [2:0] DirRight = 3'd2;
  localparam logic [2:0] DirDown  = 3'd3;
  localparam logic [2:0] DirLeft  = 3'd4;

  logic [3:0]           raw;
  logic [3:0]           s1_q, s2_q, level_q, level_d, levelPrev_q, press_q;
  logic [3:0][CntW-1:0] cnt_q, cnt_d;

  logic [2:0] dir_q, dir_d, q0_q, q0_d, q1_q, q1_d;
  logic [1:0] count_q, count_d, afterPop;
  logic       chg_q, chg_d, rej_q, rej_d, drop_q, drop_d;
  logic [2:0] cand, tail;
  logic       have, losers, pop, push, fits;

  // Bit order matches the U > R > D > L priority used below.
  assign raw = {BTNL, BTND, BTNR, BTNU};

  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      DirUp:    opposite = DirDown;
      DirRight: opposite = DirLeft;
      DirDown:  opposite = DirUp;
      DirLeft:  opposite = DirRight;
      default:  opposite = 3'd0;
    endcase
  endfunction

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) level_d[i] = s2_q[i];
        else                    cnt_d[i]   = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    cand = 3'd0;
    if      (press_q[0]) cand = DirUp;
    else if (press_q[1]) cand = DirRight;
    else if (press_q[2]) cand = DirDown;
    else if (press_q[3]) cand = DirLeft;
    have   = |press_q;
    losers = (press_q & (press_q - 4'd1)) != 4'd0;

    // Tail comes from pre-edge state so a same-edge pop never changes the verdict.
    case (count_q)
      2'd0:    tail = dir_q;
      2'd1:    tail = q0_q;
      default: tail = q1_q;
    endcase

    pop      = tick && (count_q != 2'd0);
    rej_d    = have && ((cand == tail) || (cand == opposite(tail)));
    fits     = (count_q != 2'd2) || pop;
    push     = have && !rej_d && fits;
    drop_d   = losers || (have && !rej_d && !fits);
    afterPop = count_q - {1'b0, pop};

    q0_d  = q0_q;
    q1_d  = q1_q;
    dir_d = dir_q;
    chg_d = 1'b0;
    if (pop) begin
      dir_d = q0_q;
      q0_d  = q1_q;
      chg_d = (q0_q != dir_q);
    end
    if (push) begin
      if (afterPop == 2'd0) q0_d = cand;
      else                  q1_d = cand;
    end
    count_d = afterPop + {1'b0, push};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      cnt_q       <= '0;
      level_q     <= '0;
      levelPrev_q <= '0;
      press_q     <= '0;
      dir_q       <= DirRight;
      q0_q        <= 3'd0;
      q1_q        <= 3'd0;
      count_q     <= 2'd0;
      chg_q       <= 1'b0;
      rej_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      s1_q        <= raw;
      s2_q        <= s1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      levelPrev_q <= level_q;
      press_q     <= level_q & ~levelPrev_q;
      dir_q       <= dir_d;
      q0_q        <= q0_d;
      q1_q        <= q1_d;
      count_q     <= count_d;
      chg_q       <= chg_d;
      rej_q       <= rej_d;
      drop_q      <= drop_d;
    end
  end

  assign dir         = dir_q;
  assign dir_changed = chg_q;
  assign queue_count = count_q;
  assign reject      = rej_q;
  assign drop        = drop_q;

endmodule
